// File: rtl/pwr_pkg.sv
// Shared definitions for the regulator power sequencer: state encodings and
// the status flags each state drives.
package pwr_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_ON        = 3'd3,
    ST_RAMP_DOWN = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  // {all_good, busy, fault} as seen while sitting in state s
  function automatic logic [2:0] st_flags(state_t s);
    case (s)
      ST_ON:                              st_flags = 3'b100;
      ST_RAMP_UP, ST_SETTLE, ST_RAMP_DOWN: st_flags = 3'b010;
      ST_FAULT:                           st_flags = 3'b001;
      default:                            st_flags = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/pgood_sync.sv
// Two-flop synchroniser for the raw regulator power-good lines.
module pgood_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/power_seq_ctl.sv
// Brings N regulators up in order (each gated on its own power-good), tears
// them down in reverse, and sheds every rail on timeout or brown-out.
module power_seq_ctl
  import pwr_pkg::*;
#(
  parameter int N_RAILS     = 4,
  parameter int CNT_W       = 16,
  parameter int SETTLE_CYC  = 1000,
  parameter int TIMEOUT_CYC = 50000,
  localparam int IDX_W      = (N_RAILS > 1) ? $clog2(N_RAILS) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic               clr_fault,
  input  logic [N_RAILS-1:0] pgood,
  output logic [N_RAILS-1:0] en,
  output logic               all_good,
  output logic               busy,
  output logic               fault,
  output logic [IDX_W-1:0]   fault_rail,
  output logic [ST_W-1:0]    state
);

  localparam logic [CNT_W-1:0] SET_END = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_END  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(N_RAILS - 1);

  state_t             st;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt, cnt_inc;
  logic [N_RAILS-1:0] pg_s, lost;
  logic               bo;
  logic [IDX_W-1:0]   bo_rail;

  pgood_sync #(.W(N_RAILS)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pgood),
    .q       (pg_s)
  );

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  assign state   = st;

  // Rails already up must stay good; the rail being ramped counts once it has settled.
  always_comb begin
    lost    = '0;
    bo      = 1'b0;
    bo_rail = '0;
    for (int j = 0; j < N_RAILS; j++)
      if (!pg_s[j] && (j < int'(idx) || (j == int'(idx) && st != ST_RAMP_UP)))
        lost[j] = 1'b1;
    for (int j = N_RAILS - 1; j >= 0; j--)
      if (lost[j]) begin
        bo      = 1'b1;
        bo_rail = IDX_W'(j);
      end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st                      <= ST_IDLE;
      idx                     <= '0;
      cnt                     <= '0;
      en                      <= '0;
      fault_rail              <= '0;
      {all_good, busy, fault} <= 3'b000;
    end else begin
      case (st)
        ST_IDLE:
          if (start && !stop) begin
            st                      <= ST_RAMP_UP;
            idx                     <= '0;
            cnt                     <= '0;
            en                      <= N_RAILS'(1);
            {all_good, busy, fault} <= st_flags(ST_RAMP_UP);
          end
        ST_RAMP_UP, ST_SETTLE, ST_ON: begin
          if (bo) begin
            st                      <= ST_FAULT;
            en                      <= '0;
            fault_rail              <= bo_rail;
            {all_good, busy, fault} <= st_flags(ST_FAULT);
          end else if (stop) begin
            st                      <= ST_RAMP_DOWN;
            en[idx]                 <= 1'b0;
            cnt                     <= '0;
            {all_good, busy, fault} <= st_flags(ST_RAMP_DOWN);
          end else if (st == ST_RAMP_UP) begin
            if (pg_s[idx]) begin
              st  <= ST_SETTLE;
              cnt <= '0;
            end else if (cnt == TO_END) begin
              st                      <= ST_FAULT;
              en                      <= '0;
              fault_rail              <= idx;
              {all_good, busy, fault} <= st_flags(ST_FAULT);
            end else begin
              cnt <= cnt_inc;
            end
          end else if (st == ST_SETTLE) begin
            if (cnt == SET_END) begin
              if (idx == LAST) begin
                st                      <= ST_ON;
                {all_good, busy, fault} <= st_flags(ST_ON);
              end else begin
                st                   <= ST_RAMP_UP;
                idx                  <= idx + IDX_W'(1);
                en[idx + IDX_W'(1)]  <= 1'b1;
                cnt                  <= '0;
              end
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        // Power-good is deliberately not watched here: rails are expected to fall.
        ST_RAMP_DOWN:
          if (cnt == SET_END) begin
            if (idx == '0) begin
              st                      <= ST_IDLE;
              cnt                     <= '0;
              {all_good, busy, fault} <= st_flags(ST_IDLE);
            end else begin
              idx                 <= idx - IDX_W'(1);
              en[idx - IDX_W'(1)] <= 1'b0;
              cnt                 <= '0;
            end
          end else begin
            cnt <= cnt_inc;
          end
        ST_FAULT:
          if (clr_fault) begin
            st                      <= ST_IDLE;
            idx                     <= '0;
            cnt                     <= '0;
            {all_good, busy, fault} <= st_flags(ST_IDLE);
          end
        default: begin
          st                      <= ST_IDLE;
          idx                     <= '0;
          cnt                     <= '0;
          en                      <= '0;
          {all_good, busy, fault} <= st_flags(ST_IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_power_seq_ctl.sv
// Directed bench for power_seq_ctl with a simple regulator model.
module tb_power_seq_ctl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, clr_fault = 1'b0;
  logic [3:0] pgood;
  logic [3:0] en;
  logic       all_good, busy, fault;
  logic [1:0] fault_rail;
  logic [2:0] state;

  logic [3:0] pg_m = '0, stuck = '0, drop = '0;
  int         dly [4] = '{default: 0};
  int         n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  power_seq_ctl #(
    .N_RAILS(4), .CNT_W(16), .SETTLE_CYC(4), .TIMEOUT_CYC(20)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .clr_fault(clr_fault), .pgood(pgood), .en(en), .all_good(all_good),
    .busy(busy), .fault(fault), .fault_rail(fault_rail), .state(state)
  );

  // Regulator model: power-good follows enable after three negedges unless stuck.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!en[i]) begin
        dly[i]  <= 0;
        pg_m[i] <= 1'b0;
      end else begin
        if (dly[i] < 3) dly[i] <= dly[i] + 1;
        pg_m[i] <= (dly[i] >= 2) && !stuck[i];
      end
    end
  end
  assign pgood = pg_m & ~drop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic next_en(input string tag, input logic [3:0] exp, input int max);
    logic [3:0] prev;
    prev = en;
    for (int i = 0; i < max && en == prev; i++) tick();
    chk(tag, en, exp);
  endtask

  task automatic wait_en(input string tag, input logic [3:0] exp, input int max);
    for (int i = 0; i < max && en != exp; i++) tick();
    chk(tag, en, exp);
  endtask

  task automatic wait_st(input string tag, input logic [2:0] exp, input int max);
    for (int i = 0; i < max && state != exp; i++) tick();
    chk(tag, state, exp);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_fault = 1'b1; tick(); clr_fault = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] dn [3];
    int k;
    dn = '{4'b0011, 4'b0001, 4'b0000};

    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_en", en, 4'b0000);
    chk("rst_st", state, 3'd0);
    chk("rst_flags", {all_good, busy, fault}, 3'b000);
    chk("rst_frail", fault_rail, 2'd0);

    // 1: full ramp in order
    pulse_start();
    chk("up_en0", en, 4'b0001);
    chk("up_busy", busy, 1'b1);
    next_en("up_en1", 4'b0011, 40);
    next_en("up_en2", 4'b0111, 40);
    next_en("up_en3", 4'b1111, 40);
    wait_st("up_on", 3'd3, 40);
    chk("up_flags", {all_good, busy, fault}, 3'b100);

    // 4 is run from here: orderly power-down
    stop = 1'b1; tick(); stop = 1'b0;
    chk("dn_en0", en, 4'b0111);
    chk("dn_st", state, 3'd4);
    chk("dn_busy", busy, 1'b1);
    for (int s = 0; s < 3; s++) begin
      repeat (4) tick();
      chk("dn_step", en, dn[s]);
    end
    repeat (4) tick();
    chk("dn_idle", state, 3'd0);
    chk("dn_nofault", fault, 1'b0);

    // 2: rail 2 never reports good -> timeout
    stuck = 4'b0100;
    pulse_start();
    next_en("to_en1", 4'b0011, 40);
    next_en("to_en2", 4'b0111, 40);
    k = 1;
    while (k <= 30) begin
      tick();
      if (fault) break;
      k++;
    end
    chk("to_lat", k, 20);
    chk("to_frail", fault_rail, 2'd2);
    chk("to_st", state, 3'd5);
    tick();
    chk("to_en", en, 4'b0000);
    pulse_start();
    chk("flt_start_ign", state, 3'd5);
    stuck = '0;
    pulse_clr();
    chk("clr_idle", state, 3'd0);

    // 3: brown-out on rail 1 while ON
    pulse_start();
    wait_st("bo_on", 3'd3, 100);
    drop = 4'b0010;
    repeat (3) tick();
    drop = '0;
    wait_st("bo_st", 3'd5, 5);
    chk("bo_frail", fault_rail, 2'd1);
    chk("bo_en", en, 4'b0000);
    pulse_clr();
    chk("bo_clr", state, 3'd0);
    chk("bo_frail_hold", fault_rail, 2'd1);
    pulse_start();
    wait_st("bo_reramp", 3'd3, 100);
    chk("bo_reramp_en", en, 4'b1111);

    // 6a: brown-out of rail 0 arriving with STOP wins over ramp-down
    drop = 4'b0001;
    tick(); tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("pri_st", state, 3'd5);
    chk("pri_frail", fault_rail, 2'd0);
    chk("pri_en", en, 4'b0000);
    drop = '0;
    pulse_clr();

    // 6b: START with STOP in IDLE is ignored
    start = 1'b1; stop = 1'b1;
    repeat (3) tick();
    chk("ss_st", state, 3'd0);
    chk("ss_en", en, 4'b0000);
    start = 1'b0; stop = 1'b0;

    // 5: async reset during rail 1 settle
    pulse_start();
    wait_en("rs_en1", 4'b0011, 40);
    wait_st("rs_settle", 3'd2, 20);
    #2 reset_n = 1'b0;
    #1 chk("rs_en_async", en, 4'b0000);
    chk("rs_st_async", state, 3'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rs_st", state, 3'd0);
    chk("rs_en", en, 4'b0000);
    chk("rs_flags", {all_good, busy, fault}, 3'b000);
    chk("rs_frail", fault_rail, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
